// File: rtl/multicycle_controller_pkg.sv
// Shared definitions for the multi-cycle RV32I control FSM.
// Holds the supported opcodes, the state encoding and the encodings of
// every datapath select driven by the controller.
package multicycle_controller_pkg;

    // Supported opcodes (instr[6:0])
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    // FSM states
    typedef logic [3:0] state_t;
    localparam state_t S_FETCH    = 4'd0;
    localparam state_t S_DECODE   = 4'd1;
    localparam state_t S_MEMADR   = 4'd2;
    localparam state_t S_MEMREAD  = 4'd3;
    localparam state_t S_MEMWB    = 4'd4;
    localparam state_t S_MEMWRITE = 4'd5;
    localparam state_t S_EXECR    = 4'd6;
    localparam state_t S_ALUWB    = 4'd7;
    localparam state_t S_BEQ      = 4'd8;
    localparam state_t S_HALT     = 4'd9;

    // ALU A operand select
    localparam logic [1:0] SRCA_PC     = 2'b00;
    localparam logic [1:0] SRCA_OLDPC  = 2'b01;
    localparam logic [1:0] SRCA_RS1    = 2'b10;

    // ALU B operand select
    localparam logic [1:0] SRCB_RS2    = 2'b00;
    localparam logic [1:0] SRCB_IMM    = 2'b01;
    localparam logic [1:0] SRCB_FOUR   = 2'b10;

    // ALU control
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // Immediate format
    localparam logic [1:0] IMM_I       = 2'b00;
    localparam logic [1:0] IMM_S       = 2'b01;
    localparam logic [1:0] IMM_B       = 2'b10;

    // Result mux select
    localparam logic [1:0] RES_ALUOUT  = 2'b00;
    localparam logic [1:0] RES_MDR     = 2'b01;
    localparam logic [1:0] RES_ALU     = 2'b10;

endpackage

// File: rtl/multicycle_controller_mem_wait_timer.sv
// Memory wait timer shared by FETCH, MEMREAD and MEMWRITE.
// Counts consecutive cycles spent in a memory state without mem_ready and
// flags expiry in the cycle whose increment would reach MEM_TIMEOUT.
// Ports:
//   clk, reset     - clock and synchronous active-high reset
//   in_mem_state   - FSM currently sits in a memory-access state
//   mem_ready      - memory completes the access this cycle
//   expired        - give up on this access (never set when mem_ready = 1)
module multicycle_controller_mem_wait_timer #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic in_mem_state,
    input  logic mem_ready,
    output logic expired
);
    localparam int CNT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(MEM_TIMEOUT - 1);

    logic [CNT_W-1:0] wait_cnt;
    logic             waiting;

    assign waiting = in_mem_state && !mem_ready;

    // Any cycle that is not a stalled memory cycle clears the count, which
    // covers both leaving the state and the ready cycle itself.
    always_ff @(posedge clk) begin
        if (reset || !waiting) begin
            wait_cnt <= '0;
        end else if (wait_cnt != '1) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

    // A ready arriving on the limit cycle wins because waiting is then low.
    assign expired = (MEM_TIMEOUT != 0) && waiting && (wait_cnt == LAST);

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle control FSM for the RV32I subset core (lw, sw, R-type, beq).
// Sequences the shared datapath through fetch/decode/execute/memory/
// writeback, handshakes with a unified memory port, counts retired
// instructions and halts on illegal opcodes or memory timeouts.
// Ports:
//   clk, reset        - clock, synchronous active-high reset
//   op, zero          - opcode from IR, ALU zero flag
//   mem_ready         - memory completes the current access
//   mem_req/mem_write - memory request and store strobe
//   adr_src, ir_write, pc_write, reg_write - datapath enables/selects
//   alu_src_a/b, alu_op, imm_src, result_src - datapath mux controls
//   illegal, timeout  - sticky fault flags
//   instret           - retired-instruction counter (wraps)
module multicycle_controller
    import multicycle_controller_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int INSTRET_W   = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [6:0]           op,
    input  logic                 zero,
    input  logic                 mem_ready,
    output logic                 mem_req,
    output logic                 mem_write,
    output logic                 adr_src,
    output logic                 ir_write,
    output logic                 pc_write,
    output logic                 reg_write,
    output logic [1:0]           alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [1:0]           alu_op,
    output logic [1:0]           imm_src,
    output logic [1:0]           result_src,
    output logic                 illegal,
    output logic                 timeout,
    output logic [INSTRET_W-1:0] instret
);
    state_t state_q;
    state_t state_d;
    logic   retire;
    logic   set_illegal;
    logic   set_timeout;
    logic   in_mem_state;
    logic   wait_expired;

    assign in_mem_state = (state_q == S_FETCH) || (state_q == S_MEMREAD) ||
                          (state_q == S_MEMWRITE);

    multicycle_controller_mem_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_timer (
        .clk          (clk),
        .reset        (reset),
        .in_mem_state (in_mem_state),
        .mem_ready    (mem_ready),
        .expired      (wait_expired)
    );

    // Next-state, retire and fault detection
    always_comb begin
        state_d     = state_q;
        retire      = 1'b0;
        set_illegal = 1'b0;
        set_timeout = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (mem_ready) begin
                    state_d = S_DECODE;
                end else if (wait_expired) begin
                    state_d     = S_HALT;
                    set_timeout = 1'b1;
                end
            end
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECR;
                    OP_BEQ:       state_d = S_BEQ;
                    default: begin
                        state_d     = S_HALT;
                        set_illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR:  state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD: begin
                if (mem_ready) begin
                    state_d = S_MEMWB;
                end else if (wait_expired) begin
                    state_d     = S_HALT;
                    set_timeout = 1'b1;
                end
            end
            S_MEMWB: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_MEMWRITE: begin
                if (mem_ready) begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end else if (wait_expired) begin
                    state_d     = S_HALT;
                    set_timeout = 1'b1;
                end
            end
            S_EXECR: state_d = S_ALUWB;
            S_ALUWB, S_BEQ: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            instret <= '0;
            illegal <= 1'b0;
            timeout <= 1'b0;
        end else begin
            state_q <= state_d;
            if (retire) begin
                instret <= instret + INSTRET_W'(1);
            end
            if (set_illegal) begin
                illegal <= 1'b1;
            end
            if (set_timeout) begin
                timeout <= 1'b1;
            end
        end
    end

    // Datapath controls; reset forces every enable and select to zero
    always_comb begin
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_RS2;
        alu_op     = ALUOP_ADD;
        imm_src    = IMM_I;
        result_src = RES_ALUOUT;
        if (!reset) begin
            case (state_q)
                S_FETCH: begin
                    mem_req    = 1'b1;
                    alu_src_a  = SRCA_PC;
                    alu_src_b  = SRCB_FOUR;
                    alu_op     = ALUOP_ADD;
                    result_src = RES_ALU;
                    ir_write   = mem_ready;
                    pc_write   = mem_ready;
                end
                S_DECODE: begin
                    // Precompute the branch target into ALUOut
                    alu_src_a = SRCA_OLDPC;
                    alu_src_b = SRCB_IMM;
                    imm_src   = IMM_B;
                    alu_op    = ALUOP_ADD;
                end
                S_MEMADR: begin
                    alu_src_a = SRCA_RS1;
                    alu_src_b = SRCB_IMM;
                    alu_op    = ALUOP_ADD;
                    imm_src   = (op == OP_SW) ? IMM_S : IMM_I;
                end
                S_MEMREAD: begin
                    mem_req = 1'b1;
                    adr_src = 1'b1;
                end
                S_MEMWB: begin
                    result_src = RES_MDR;
                    reg_write  = 1'b1;
                end
                S_MEMWRITE: begin
                    mem_req   = 1'b1;
                    mem_write = 1'b1;
                    adr_src   = 1'b1;
                end
                S_EXECR: begin
                    alu_src_a = SRCA_RS1;
                    alu_src_b = SRCB_RS2;
                    alu_op    = ALUOP_FUNCT;
                end
                S_ALUWB: begin
                    result_src = RES_ALUOUT;
                    reg_write  = 1'b1;
                end
                S_BEQ: begin
                    alu_src_a  = SRCA_RS1;
                    alu_src_b  = SRCB_RS2;
                    alu_op     = ALUOP_SUB;
                    result_src = RES_ALUOUT;
                    pc_write   = zero;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller. Instruction-level model
// expands each instruction into its expected per-cycle control vectors;
// a monitor on the falling edge pops and compares them.
module tb_multicycle_controller;
    localparam int TMO = 4;
    localparam int IW  = 8;
    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] BQ  = 7'b1100011;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [6:0]    op = '0;
    logic          zero = 1'b0;
    logic          mem_ready = 1'b0;
    logic          mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
    logic [1:0]    alu_src_a, alu_src_b, alu_op, imm_src, result_src;
    logic          illegal, timeout;
    logic [IW-1:0] instret;

    multicycle_controller #(.MEM_TIMEOUT(TMO), .INSTRET_W(IW)) dut (
        .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_write(mem_write), .adr_src(adr_src),
        .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .imm_src(imm_src), .result_src(result_src), .illegal(illegal),
        .timeout(timeout), .instret(instret)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          mem_req;
        logic          mem_write;
        logic          adr_src;
        logic          ir_write;
        logic          pc_write;
        logic          reg_write;
        logic [1:0]    src_a;
        logic [1:0]    src_b;
        logic [1:0]    aop;
        logic [1:0]    imm;
        logic [1:0]    res;
        logic          illegal;
        logic          timeout;
        logic [IW-1:0] instret;
    } vec_t;

    vec_t  exp_q[$];
    string name_q[$];
    int    total = 0;
    int    bad = 0;
    int    m_instret = 0;
    bit    m_illegal = 0;
    bit    m_timeout = 0;

    vec_t  mon_e, mon_g;
    string mon_n;

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            mon_n = name_q.pop_front();
            mon_g = '{mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
                      alu_src_a, alu_src_b, alu_op, imm_src, result_src,
                      illegal, timeout, instret};
            total++;
            if (mon_g !== mon_e) begin
                bad++;
                $display("FAIL %s @%0t: got=%h expected=%h", mon_n, $time, mon_g, mon_e);
            end
        end
    end

    function automatic vec_t base();
        vec_t v = '0;
        v.illegal = m_illegal;
        v.timeout = m_timeout;
        v.instret = IW'(m_instret);
        return v;
    endfunction

    function automatic logic rb();
        return logic'($urandom_range(0, 1));
    endfunction

    function automatic logic [6:0] rop();
        return 7'($urandom_range(0, 127));
    endfunction

    function automatic void do_retire();
        m_instret = (m_instret + 1) % (1 << IW);
    endfunction

    task automatic step(input logic rst, input logic [6:0] o, input logic z,
                        input logic r, input vec_t e, input string n);
        reset = rst; op = o; zero = z; mem_ready = r;
        exp_q.push_back(e);
        name_q.push_back(n);
        @(posedge clk);
        #1;
    endtask

    // Reset: flags/counter still show old values in the first reset cycle
    task automatic do_reset(input int n, input logic r1);
        step(1'b1, rop(), rb(), r1, base(), "reset_first");
        m_instret = 0; m_illegal = 0; m_timeout = 0;
        for (int i = 1; i < n; i++) step(1'b1, rop(), rb(), rb(), base(), "reset_hold");
    endtask

    task automatic halt_then_reset();
        int k = $urandom_range(1, 3);
        for (int i = 0; i < k; i++) step(1'b0, rop(), rb(), rb(), base(), "halt");
        do_reset(2, rb());
    endtask

    // kind: 0 = fetch, 1 = load read, 2 = store write; w = stall cycles
    function automatic vec_t e_mem(input int kind, input logic rdy);
        vec_t e = base();
        e.mem_req = 1'b1;
        if (kind == 0) begin
            e.src_b = 2'b10; e.res = 2'b10; e.ir_write = rdy; e.pc_write = rdy;
        end else begin
            e.adr_src = 1'b1; e.mem_write = (kind == 2);
        end
        return e;
    endfunction

    task automatic mem_phase(input int kind, input logic [6:0] o, input int w, output bit tmo);
        tmo = 0;
        if (TMO != 0 && w >= TMO) begin
            for (int i = 0; i < TMO; i++) step(1'b0, o, rb(), 1'b0, e_mem(kind, 1'b0), "mem_stall");
            m_timeout = 1;
            tmo = 1;
        end else begin
            for (int i = 0; i < w; i++) step(1'b0, o, rb(), 1'b0, e_mem(kind, 1'b0), "mem_stall");
            step(1'b0, o, rb(), 1'b1, e_mem(kind, 1'b1), "mem_ready");
            if (kind == 2) do_retire();
        end
    endtask

    task automatic decode_step(input logic [6:0] o);
        vec_t e = base();
        e.src_a = 2'b01; e.src_b = 2'b01; e.imm = 2'b10;
        step(1'b0, o, rb(), rb(), e, "decode");
    endtask

    task automatic memadr_step(input logic [6:0] o);
        vec_t e = base();
        e.src_a = 2'b10; e.src_b = 2'b01; e.imm = (o == SW) ? 2'b01 : 2'b00;
        step(1'b0, o, rb(), rb(), e, "memadr");
    endtask

    task automatic do_instr(input logic [6:0] o, input logic z, input int wf, input int wm);
        bit   tmo;
        vec_t e;
        mem_phase(0, rop(), wf, tmo);
        if (tmo) begin halt_then_reset(); return; end
        decode_step(o);
        if (o == LW || o == SW) begin
            memadr_step(o);
            mem_phase((o == LW) ? 1 : 2, o, wm, tmo);
            if (tmo) begin halt_then_reset(); return; end
            if (o == LW) begin
                e = base(); e.res = 2'b01; e.reg_write = 1'b1;
                step(1'b0, o, rb(), rb(), e, "memwb");
                do_retire();
            end
        end else if (o == RT) begin
            e = base(); e.src_a = 2'b10; e.aop = 2'b10;
            step(1'b0, o, rb(), rb(), e, "execr");
            e = base(); e.reg_write = 1'b1;
            step(1'b0, o, rb(), rb(), e, "aluwb");
            do_retire();
        end else if (o == BQ) begin
            e = base(); e.src_a = 2'b10; e.aop = 2'b01; e.pc_write = z;
            step(1'b0, o, z, rb(), e, "beq");
            do_retire();
        end else begin
            m_illegal = 1;
            halt_then_reset();
        end
    endtask

    function automatic int rwait();
        if ($urandom_range(0, 15) == 0) return TMO + int'($urandom_range(0, 1));
        return int'($urandom_range(0, TMO - 1));
    endfunction

    initial begin
        bit tmo;
        logic [6:0] o;
        reset = 1'b1;
        @(posedge clk); #1;
        step(1'b1, rop(), rb(), rb(), base(), "reset_state");
        // Directed cases
        do_instr(RT, 1'b0, 0, 0);
        do_instr(LW, 1'b0, 0, 3);
        do_instr(BQ, 1'b1, 0, 0);
        do_instr(BQ, 1'b0, 1, 0);
        do_instr(SW, 1'b0, 0, 0);
        do_instr(SW, 1'b0, 0, TMO);           // store never acknowledged
        do_instr(7'b1111111, 1'b0, 0, 0);     // illegal opcode
        do_instr(LW, 1'b0, TMO - 1, TMO - 1); // ready on the limit cycle
        do_instr(RT, 1'b0, TMO + 1, 0);       // fetch timeout
        // Reset in MEMWRITE while memory acknowledges
        do_instr(RT, 1'b0, 0, 0);
        mem_phase(0, rop(), 0, tmo);
        decode_step(SW);
        memadr_step(SW);
        do_reset(1, 1'b1);
        do_instr(LW, 1'b0, 0, 0);
        // Enough retirements without a reset to wrap the counter
        for (int i = 0; i < 260; i++) do_instr(($urandom_range(0, 1) != 0) ? RT : BQ, rb(), 0, 0);
        // Random mix including stalls, timeouts and illegal opcodes
        for (int i = 0; i < 200; i++) begin
            case ($urandom_range(0, 9))
                0, 1:    o = LW;
                2, 3:    o = SW;
                4, 5, 6: o = RT;
                7, 8:    o = BQ;
                default: o = rop();
            endcase
            do_instr(o, rb(), rwait(), rwait());
        end
        repeat (2) @(posedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got=%0d pending expected=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
